ixc_assign_pipe: RTL

- Parametrised, elastic successor to the fixed-width bitwise assign template.
- Carries a WIDTH-bit bus from R to L through STAGES register slices.
- Each slice has a valid/ready handshake, full throughput and backpressure.
- Used by the emulation compiler wherever a long assign net must be retimed across partition or clock-tree boundaries without losing flow control.

---
 rtl/ixc_assign_pkg.sv | 24 ++
 rtl/ixc_assign_slice.sv | 81 ++++++++
 rtl/ixc_assign_pipe.sv | 138 +++++++++++++
 3 files changed

// File: rtl/ixc_assign_pkg.sv
`timescale 1ns/1ps
// ixc_assign_pkg: shared constants and helpers for the ixc_assign_pipe slice.
// Optional build macro used by the files that import this package:
//   IXC_ASSIGN_PARITY_EN - adds a per-slice parity bit and a sticky parity_err output.
package ixc_assign_pkg;

    // Legal parameter ranges for the pipeline.
    localparam int WIDTH_MIN  = 1;
    localparam int WIDTH_MAX  = 1024;
    localparam int STAGES_MIN = 1;
    localparam int STAGES_MAX = 8;

    // Width of the occupancy counter: it must be able to hold the value STAGES.
    function automatic int occ_w(input int stages);
        return $clog2(stages + 1);
    endfunction

    // True when WIDTH and STAGES fall inside the supported ranges.
    function automatic bit params_ok(input int width, input int stages);
        return (width >= WIDTH_MIN) && (width <= WIDTH_MAX) &&
               (stages >= STAGES_MIN) && (stages <= STAGES_MAX);
    endfunction

endpackage

// File: rtl/ixc_assign_slice.sv
`timescale 1ns/1ps
// ixc_assign_slice: one elastic register slice (valid + data, optional parity).
// Loads from its source whenever load (the downstream ready) is high; the data
// register only changes when the incoming word is valid, so bubbles do not
// toggle it. Flush and reset return the slice to empty with RST_DATA.
// Optional build macro: IXC_ASSIGN_PARITY_EN adds the parity bit.
module ixc_assign_slice
    import ixc_assign_pkg::*;
#(
    parameter int               WIDTH    = 17,
    parameter logic [WIDTH-1:0] RST_DATA = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             load,
    input  logic             src_valid,
    input  logic [WIDTH-1:0] src_data,
`ifdef IXC_ASSIGN_PARITY_EN
    input  logic             src_par,
    output logic             par_q,
`endif
    output logic             valid_d,
    output logic             valid_q,
    output logic [WIDTH-1:0] data_q
);

    // The slice state; the data width is a module parameter, so the type is
    // declared here rather than in the shared package.
    typedef struct packed {
        logic             valid;
        logic [WIDTH-1:0] data;
`ifdef IXC_ASSIGN_PARITY_EN
        logic             parity;
`endif
    } slice_t;

    slice_t q;

    // Next valid state; also consumed by the top-level occupancy count.
    always_comb begin
        valid_d = q.valid;
        if (flush) begin
            valid_d = 1'b0;
        end else if (load) begin
            valid_d = src_valid;
        end
    end

    // Slice register: flush wins, then load; data moves only with a valid word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.valid <= 1'b0;
            q.data  <= RST_DATA;
`ifdef IXC_ASSIGN_PARITY_EN
            q.parity <= ^RST_DATA;
`endif
        end else if (flush) begin
            q.valid <= 1'b0;
            q.data  <= RST_DATA;
`ifdef IXC_ASSIGN_PARITY_EN
            q.parity <= ^RST_DATA;
`endif
        end else begin
            q.valid <= valid_d;
            if (load && src_valid) begin
                q.data <= src_data;
`ifdef IXC_ASSIGN_PARITY_EN
                q.parity <= src_par;
`endif
            end
        end
    end

    assign valid_q = q.valid;
    assign data_q  = q.data;
`ifdef IXC_ASSIGN_PARITY_EN
    assign par_q   = q.parity;
`endif

endmodule

// File: rtl/ixc_assign_pipe.sv
`timescale 1ns/1ps
// ixc_assign_pipe: WIDTH-bit bus carried from R to L through STAGES elastic
// register slices with full throughput and backpressure.
// Handshake: a word moves on an edge where valid and ready are both high; a
// source holding valid without ready must keep valid asserted until accepted
// (flush is the only exception). The out_ready -> in_ready path is a purely
// combinational ready chain, deliberately not registered.
// Optional build macro: IXC_ASSIGN_PARITY_EN adds inj_par / parity_err.
module ixc_assign_pipe
    import ixc_assign_pkg::*;
#(
    parameter int               WIDTH    = 17,
    parameter int               STAGES   = 2,
    parameter logic [WIDTH-1:0] RST_DATA = '0
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        flush,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [WIDTH-1:0]            R,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [WIDTH-1:0]            L,
    output logic [occ_w(STAGES)-1:0]    occupancy
`ifdef IXC_ASSIGN_PARITY_EN
    ,
    input  logic                        inj_par,
    output logic                        parity_err
`endif
);

    localparam int OCC_W     = occ_w(STAGES);
    localparam bit PARAMS_OK = params_ok(WIDTH, STAGES);

    logic [STAGES:0]   rdy;
    logic [STAGES-1:0] valid_q;
    logic [STAGES-1:0] valid_d;
    logic [WIDTH-1:0]  data_q [STAGES];
    logic [OCC_W-1:0]  occ_d;
    logic [OCC_W-1:0]  occ_q;
`ifdef IXC_ASSIGN_PARITY_EN
    logic [STAGES-1:0] par_q;
`endif

    // Ready chain: a slice can load when it is empty or its successor loads.
    always_comb begin
        rdy         = '0;
        rdy[STAGES] = out_ready;
        for (int i = STAGES - 1; i >= 0; i--) begin
            rdy[i] = ~valid_q[i] | rdy[i+1];
        end
    end

    for (genvar i = 0; i < STAGES; i++) begin : g_slice
        logic             src_valid;
        logic [WIDTH-1:0] src_data;
`ifdef IXC_ASSIGN_PARITY_EN
        logic             src_par;
`endif
        if (i == 0) begin : g_head
            assign src_valid = in_valid & ~flush;
            assign src_data  = R;
`ifdef IXC_ASSIGN_PARITY_EN
            assign src_par   = (^R) ^ inj_par;
`endif
        end else begin : g_body
            assign src_valid = valid_q[i-1];
            assign src_data  = data_q[i-1];
`ifdef IXC_ASSIGN_PARITY_EN
            assign src_par   = par_q[i-1];
`endif
        end

        ixc_assign_slice #(
            .WIDTH    (WIDTH),
            .RST_DATA (RST_DATA)
        ) u_slice (
            .clk       (clk),
            .rst_n     (rst_n),
            .flush     (flush),
            .load      (rdy[i]),
            .src_valid (src_valid),
            .src_data  (src_data),
`ifdef IXC_ASSIGN_PARITY_EN
            .src_par   (src_par),
            .par_q     (par_q[i]),
`endif
            .valid_d   (valid_d[i]),
            .valid_q   (valid_q[i]),
            .data_q    (data_q[i])
        );
    end

    assign in_ready  = rdy[0] & ~flush;
    assign out_valid = valid_q[STAGES-1] & ~flush;
    assign L         = data_q[STAGES-1];

    // Popcount of the next valid vector, so occupancy moves with valid_q.
    always_comb begin
        occ_d = '0;
        for (int i = 0; i < STAGES; i++) begin
            occ_d = occ_d + OCC_W'(valid_d[i]);
        end
    end

    // Occupancy register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_q <= '0;
        end else begin
            occ_q <= occ_d;
        end
    end

    assign occupancy = occ_q;

`ifdef IXC_ASSIGN_PARITY_EN
    // Sticky parity error: recompute parity on L while a word is presented.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            parity_err <= 1'b0;
        end else if (flush) begin
            parity_err <= 1'b0;
        end else if (out_valid && ((^L) != par_q[STAGES-1])) begin
            parity_err <= 1'b1;
        end
    end
`endif

    // Parameters must sit inside the supported ranges.
    a_params : assert property (@(posedge clk) PARAMS_OK);

    // A word offered but not accepted must stay offered, unless flushed.
    a_hold_valid : assert property (@(posedge clk) disable iff (!rst_n)
        (in_valid && !in_ready && !flush) |=> in_valid);

endmodule
